// File: rtl/cmp_scan_ctrl.sv
// Sequencer that loads one ROWS x COLS glyph into a local buffer, kicks the compare ALU and serves its column / row-pair requests.
// Latency: start to alu_start is ROWS+3 cycles, request to ready is 1 cycle, alu_done to done is 1 cycle.
// Backpressure: none; start while busy and requests beyond the last column / row pair are dropped, and a silent ALU times out to err.
module cmp_scan_ctrl #(
  parameter int ROWS    = 64,
  parameter int COLS    = 24,
  parameter int ADDR_W  = 6,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       result,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [COLS-1:0]   mem_rdata,
  output logic              alu_start,
  input  logic              alu_nextcol,
  input  logic              alu_nextrow,
  output logic [ROWS-1:0]   alu_col,
  output logic              alu_col_rdy,
  output logic              alu_lastcol,
  output logic [COLS-1:0]   alu_row_top,
  output logic [COLS-1:0]   alu_row_bot,
  output logic              alu_row_rdy,
  input  logic              alu_done,
  input  logic [15:0]       alu_result
);

  // ld_cnt runs to ROWS+1 so the final row can land one cycle after its read
  localparam int LW = $clog2(ROWS + 2);
  localparam int CW = $clog2(COLS + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, LOAD, KICK, SCAN, FIN} state_t;

  state_t            state, state_nxt;
  logic [LW-1:0]     ld_cnt;
  logic              wr_vld;
  logic [ADDR_W-1:0] wr_addr;
  logic [COLS-1:0]   gbuf [ROWS];
  logic [CW-1:0]     col_idx;
  logic [ADDR_W-1:0] row_idx;
  logic [TW-1:0]     timer;
  logic              timeout_hit;
  logic              col_serve;
  logic              row_serve;

  assign timeout_hit = (timer == TW'(TIMEOUT));
  assign col_serve   = (state == SCAN) && alu_nextcol && (col_idx < CW'(COLS));
  assign row_serve   = (state == SCAN) && alu_nextrow && (row_idx < ADDR_W'(ROWS / 2));

  // State register; reset aborts any glyph in flight straight back to IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: LOAD waits for the final delayed write, SCAN leaves on done or timeout
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    if (ld_cnt == LW'(ROWS + 1)) state_nxt = KICK;
      KICK:    state_nxt = SCAN;
      SCAN:    if (alu_done || timeout_hit) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control outputs decoded from state so they are all low while in reset
  always_comb begin
    mem_rd_en = (state == LOAD) && (ld_cnt < LW'(ROWS));
    mem_addr  = mem_rd_en ? ld_cnt[ADDR_W-1:0] : '0;
    alu_start = (state == KICK);
    busy      = (state != IDLE);
    done      = (state == FIN);
  end

  // Load counter plus one-cycle delay of the read strobe/address to match memory latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_cnt  <= '0;
      wr_vld  <= 1'b0;
      wr_addr <= '0;
    end else begin
      wr_vld  <= mem_rd_en;
      wr_addr <= mem_addr;
      if (state == LOAD) ld_cnt <= ld_cnt + LW'(1);
      else               ld_cnt <= '0;
    end
  end

  // Glyph buffer; contents are meaningless until a load completes, so no reset
  always_ff @(posedge clk) begin
    if (wr_vld) gbuf[wr_addr] <= mem_rdata;
  end

  // Scan indices saturate at their limits; timer counts every SCAN cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_idx <= '0;
      row_idx <= '0;
      timer   <= '0;
    end else if (state == KICK) begin
      col_idx <= '0;
      row_idx <= '0;
      timer   <= '0;
    end else if (state == SCAN) begin
      timer <= timer + TW'(1);
      if (col_serve) col_idx <= col_idx + CW'(1);
      if (row_serve) row_idx <= row_idx + ADDR_W'(1);
    end
  end

  // Column and row-pair data: ready pulses for one cycle, data holds between pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_col     <= '0;
      alu_col_rdy <= 1'b0;
      alu_lastcol <= 1'b0;
      alu_row_top <= '0;
      alu_row_bot <= '0;
      alu_row_rdy <= 1'b0;
    end else begin
      alu_col_rdy <= 1'b0;
      alu_lastcol <= 1'b0;
      alu_row_rdy <= 1'b0;
      if (col_serve) begin
        for (int r = 0; r < ROWS; r++) alu_col[r] <= gbuf[r][col_idx];
        alu_col_rdy <= 1'b1;
        alu_lastcol <= (col_idx == CW'(COLS - 1));
      end
      if (row_serve) begin
        alu_row_top <= gbuf[row_idx];
        alu_row_bot <= gbuf[ADDR_W'(ROWS - 1) - row_idx];
        alu_row_rdy <= 1'b1;
      end
    end
  end

  // Result/err: cleared on accepted start, ALU done takes priority over timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err    <= 1'b0;
      result <= '0;
    end else if (state == IDLE && start) begin
      err    <= 1'b0;
      result <= '0;
    end else if (state == SCAN) begin
      if (alu_done) begin
        result <= alu_result;
      end else if (timeout_hit) begin
        err    <= 1'b1;
        result <= '0;
      end
    end
  end

endmodule

// File: tb/tb_cmp_scan_ctrl.sv
// Directed bench for cmp_scan_ctrl: glyph load, column/row serving, saturation, timeout, reset abort.
// Inputs are driven and outputs sampled on the falling clock edge.
// Glyph memory model returns row data one cycle after the read strobe.
module tb_cmp_scan_ctrl;
  localparam int ROWS = 64;
  localparam int COLS = 24;
  localparam int ADDR_W = 6;

  logic              clk, rst_n, start;
  logic              busy, done, err;
  logic [15:0]       result;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [COLS-1:0]   mem_rdata;
  logic              alu_start, alu_nextcol, alu_nextrow;
  logic [ROWS-1:0]   alu_col;
  logic              alu_col_rdy, alu_lastcol;
  logic [COLS-1:0]   alu_row_top, alu_row_bot;
  logic              alu_row_rdy, alu_done;
  logic [15:0]       alu_result;

  logic [COLS-1:0]   mem [ROWS];
  logic [141:0]      all_outs;
  int                pass_cnt = 0;
  int                chk_cnt = 0;

  assign all_outs = {busy, done, err, result, mem_rd_en, mem_addr, alu_start, alu_col,
                     alu_col_rdy, alu_lastcol, alu_row_top, alu_row_bot, alu_row_rdy};

  cmp_scan_ctrl #(.ROWS(ROWS), .COLS(COLS), .ADDR_W(ADDR_W), .TIMEOUT(255)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .err(err),
    .result(result), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .alu_start(alu_start), .alu_nextcol(alu_nextcol), .alu_nextrow(alu_nextrow),
    .alu_col(alu_col), .alu_col_rdy(alu_col_rdy), .alu_lastcol(alu_lastcol),
    .alu_row_top(alu_row_top), .alu_row_bot(alu_row_bot), .alu_row_rdy(alu_row_rdy),
    .alu_done(alu_done), .alu_result(alu_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial mem_rdata = '0;
  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

  task automatic tick;
    @(negedge clk);
  endtask

  // Pulse start and wait for alu_start; lat counts cycles from the start cycle.
  task automatic run_to_kick(output int lat, output bit addr_ok);
    lat = 0;
    addr_ok = 1'b1;
    start = 1'b1;
    for (int k = 0; k < 200; k++) begin
      tick;
      lat++;
      start = 1'b0;
      if (lat - 1 < ROWS) begin
        if (!(mem_rd_en === 1'b1 && mem_addr === 6'(lat - 1))) addr_ok = 1'b0;
      end else if (mem_rd_en !== 1'b0) addr_ok = 1'b0;
      if (alu_start === 1'b1) break;
    end
  endtask

  // Drive alu_done for one SCAN cycle and report what the FIN cycle shows.
  task automatic end_glyph(input logic [15:0] r, output logic d, output logic [15:0] res);
    alu_done = 1'b1;
    alu_result = r;
    tick;
    alu_done = 1'b0;
    alu_result = '0;
    d = done;
    res = result;
    tick;
  endtask

  task automatic test_reset;
    chk_cnt++;
    if (all_outs !== '0) $display("FAIL reset_outputs got %h exp 0", all_outs);
    else pass_cnt++;
  endtask

  task automatic test_basic;
    int lat;
    bit ok;
    for (int r = 0; r < ROWS; r++) mem[r] = '0;
    mem[10] = 24'h000038;
    run_to_kick(lat, ok);
    chk_cnt++;
    if (lat !== ROWS + 3) $display("FAIL basic_latency got %0d exp %0d", lat, ROWS + 3);
    else pass_cnt++;
    chk_cnt++;
    if (ok !== 1'b1) $display("FAIL basic_addr_seq got %0d exp 1", ok);
    else pass_cnt++;
    tick;
    alu_done = 1'b1;
    alu_result = 16'h0143;
    tick;
    alu_done = 1'b0;
    alu_result = '0;
    chk_cnt++;
    if ({done, busy, err} !== 3'b110) $display("FAIL basic_done got %b exp 110", {done, busy, err});
    else pass_cnt++;
    chk_cnt++;
    if (result !== 16'h0143) $display("FAIL basic_result got %h exp 0143", result);
    else pass_cnt++;
    tick;
    chk_cnt++;
    if ({done, busy, result} !== {2'b00, 16'h0143})
      $display("FAIL basic_after got %b %b %h exp 0 0 0143", done, busy, result);
    else pass_cnt++;
  endtask

  task automatic test_columns;
    int lat;
    bit ok;
    logic d;
    logic [15:0] res;
    for (int r = 0; r < ROWS; r++) mem[r] = (r % 2 == 0) ? 24'hAAAAAA : 24'h555555;
    run_to_kick(lat, ok);
    tick;
    alu_nextcol = 1'b1;
    tick;
    alu_nextcol = 1'b0;
    chk_cnt++;
    if ({alu_col_rdy, alu_lastcol, alu_col} !== {2'b10, 64'hAAAA_AAAA_AAAA_AAAA})
      $display("FAIL col0 got %b%b %h exp 10 aaaaaaaaaaaaaaaa", alu_col_rdy, alu_lastcol, alu_col);
    else pass_cnt++;
    alu_nextcol = 1'b1;
    tick;
    alu_nextcol = 1'b0;
    chk_cnt++;
    if ({alu_col_rdy, alu_col} !== {1'b1, 64'h5555_5555_5555_5555})
      $display("FAIL col1 got %b %h exp 1 5555555555555555", alu_col_rdy, alu_col);
    else pass_cnt++;
    tick;
    chk_cnt++;
    if ({alu_col_rdy, alu_col} !== {1'b0, 64'h5555_5555_5555_5555})
      $display("FAIL col_hold got %b %h exp 0 5555555555555555", alu_col_rdy, alu_col);
    else pass_cnt++;
    end_glyph(16'h0002, d, res);
    chk_cnt++;
    if ({d, res} !== {1'b1, 16'h0002}) $display("FAIL col_glyph_done got %b %h exp 1 0002", d, res);
    else pass_cnt++;
  endtask

  task automatic test_saturate;
    int lat, ncol, nlast, lastpos, nrow;
    bit ok;
    logic d;
    logic [15:0] res;
    logic [COLS-1:0] t0, b0, t31, b31;
    ncol = 0; nlast = 0; lastpos = 0; nrow = 0;
    t0 = '0; b0 = '0; t31 = '0; b31 = '0;
    for (int r = 0; r < ROWS; r++) mem[r] = {8'(r), 8'(255 - r), 8'hC3};
    run_to_kick(lat, ok);
    tick;
    for (int i = 0; i < 36; i++) begin
      alu_nextcol = (i < 26);
      alu_nextrow = (i < 33);
      tick;
      if (alu_col_rdy === 1'b1) begin
        ncol++;
        if (alu_lastcol === 1'b1) lastpos = ncol;
      end
      if (alu_lastcol === 1'b1) nlast++;
      if (alu_row_rdy === 1'b1) begin
        nrow++;
        if (nrow == 1) begin t0 = alu_row_top; b0 = alu_row_bot; end
        if (nrow == 32) begin t31 = alu_row_top; b31 = alu_row_bot; end
      end
    end
    alu_nextcol = 1'b0;
    alu_nextrow = 1'b0;
    chk_cnt++;
    if (ncol !== 24) $display("FAIL sat_col_count got %0d exp 24", ncol);
    else pass_cnt++;
    chk_cnt++;
    if ({nlast, lastpos} !== {32'd1, 32'd24}) $display("FAIL sat_lastcol got %0d@%0d exp 1@24", nlast, lastpos);
    else pass_cnt++;
    chk_cnt++;
    if (nrow !== 32) $display("FAIL sat_row_count got %0d exp 32", nrow);
    else pass_cnt++;
    chk_cnt++;
    if ({t0, b0} !== {mem[0], mem[63]}) $display("FAIL row_pair0 got %h/%h exp %h/%h", t0, b0, mem[0], mem[63]);
    else pass_cnt++;
    chk_cnt++;
    if ({t31, b31} !== {mem[31], mem[32]}) $display("FAIL row_pair31 got %h/%h exp %h/%h", t31, b31, mem[31], mem[32]);
    else pass_cnt++;
    end_glyph(16'h0003, d, res);
    chk_cnt++;
    if ({d, res} !== {1'b1, 16'h0003}) $display("FAIL sat_glyph_done got %b %h exp 1 0003", d, res);
    else pass_cnt++;
  endtask

  task automatic test_timeout;
    int lat, n;
    bit ok;
    run_to_kick(lat, ok);
    n = 0;
    for (int k = 0; k < 400; k++) begin
      tick;
      n++;
      if (done === 1'b1) break;
    end
    chk_cnt++;
    if (n !== 257) $display("FAIL timeout_cycles got %0d exp 257", n);
    else pass_cnt++;
    chk_cnt++;
    if ({done, err, result} !== {2'b11, 16'h0000})
      $display("FAIL timeout_err got %b %b %h exp 1 1 0000", done, err, result);
    else pass_cnt++;
    repeat (3) tick;
    chk_cnt++;
    if ({busy, err} !== 2'b01) $display("FAIL timeout_err_hold got %b exp 01", {busy, err});
    else pass_cnt++;
    // second glyph: alu_done lands exactly on the timeout cycle
    run_to_kick(lat, ok);
    chk_cnt++;
    if (err !== 1'b0) $display("FAIL start_clears_err got %b exp 0", err);
    else pass_cnt++;
    repeat (256) tick;
    alu_done = 1'b1;
    alu_result = 16'hBEEF;
    tick;
    alu_done = 1'b0;
    alu_result = '0;
    chk_cnt++;
    if ({done, err, result} !== {2'b10, 16'hBEEF})
      $display("FAIL timeout_tie got %b %b %h exp 1 0 beef", done, err, result);
    else pass_cnt++;
    tick;
  endtask

  task automatic test_reset_midload;
    int lat;
    bit ok, found;
    logic d;
    logic [15:0] res;
    found = 1'b0;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (mem_rd_en === 1'b1 && mem_addr === 6'd20) begin
        found = 1'b1;
        break;
      end
      tick;
    end
    chk_cnt++;
    if (found !== 1'b1) $display("FAIL midload_reach_addr20 got %b exp 1", found);
    else pass_cnt++;
    rst_n = 1'b0;
    #1;
    chk_cnt++;
    if (all_outs !== '0) $display("FAIL midload_reset_outputs got %h exp 0", all_outs);
    else pass_cnt++;
    tick;
    rst_n = 1'b1;
    repeat (3) tick;
    chk_cnt++;
    if ({busy, mem_rd_en} !== 2'b00) $display("FAIL post_reset_idle got %b exp 00", {busy, mem_rd_en});
    else pass_cnt++;
    for (int r = 0; r < ROWS; r++) mem[r] = 24'(r * 3);
    run_to_kick(lat, ok);
    chk_cnt++;
    if ({lat, ok} !== {32'(ROWS + 3), 1'b1})
      $display("FAIL fresh_start got lat %0d addr_ok %0d exp %0d 1", lat, ok, ROWS + 3);
    else pass_cnt++;
    tick;
    end_glyph(16'h1234, d, res);
    chk_cnt++;
    if ({d, res} !== {1'b1, 16'h1234}) $display("FAIL fresh_done got %b %h exp 1 1234", d, res);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    int lat;
    bit ok;
    logic d;
    logic [15:0] res;
    run_to_kick(lat, ok);
    tick;
    start = 1'b1;
    alu_nextcol = 1'b1;
    alu_nextrow = 1'b1;
    tick;
    start = 1'b0;
    alu_nextcol = 1'b0;
    alu_nextrow = 1'b0;
    chk_cnt++;
    if ({alu_col_rdy, alu_row_rdy} !== 2'b11) $display("FAIL both_rdy got %b exp 11", {alu_col_rdy, alu_row_rdy});
    else pass_cnt++;
    tick;
    chk_cnt++;
    if ({busy, mem_rd_en, alu_start} !== 3'b100)
      $display("FAIL start_ignored got %b exp 100", {busy, mem_rd_en, alu_start});
    else pass_cnt++;
    end_glyph(16'h0006, d, res);
    chk_cnt++;
    if ({d, res, busy, mem_rd_en} !== {1'b1, 16'h0006, 2'b00})
      $display("FAIL b2b_finish got %b %h %b%b exp 1 0006 00", d, res, busy, mem_rd_en);
    else pass_cnt++;
    alu_nextcol = 1'b1;
    tick;
    alu_nextcol = 1'b0;
    chk_cnt++;
    if (alu_col_rdy !== 1'b0) $display("FAIL idle_req_ignored got %b exp 0", alu_col_rdy);
    else pass_cnt++;
    tick;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    alu_nextcol = 1'b0;
    alu_nextrow = 1'b0;
    alu_done = 1'b0;
    alu_result = '0;
    for (int r = 0; r < ROWS; r++) mem[r] = '0;
    repeat (3) tick;
    test_reset;
    rst_n = 1'b1;
    tick;
    test_basic;
    test_columns;
    test_saturate;
    test_timeout;
    test_reset_midload;
    test_back_to_back;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
